// File: rtl/iic_slave_regs_if.sv
// Pin and register-file signals of the I2C register target.
// The slave modport faces the target; the master modport faces the pads and register file.
interface iic_slave_regs_if;
  logic        scl_in;
  logic        sda_in;
  logic        sda_out_en;
  logic [15:0] reg_addr;
  logic        reg_wr;
  logic [7:0]  reg_wdata;
  logic        reg_rd;
  logic [7:0]  reg_rdata;
  logic        busy;

  modport slave (
    input  scl_in, sda_in, reg_rdata,
    output sda_out_en, reg_addr, reg_wr, reg_wdata, reg_rd, busy
  );

  modport master (
    output scl_in, sda_in, reg_rdata,
    input  sda_out_en, reg_addr, reg_wr, reg_wdata, reg_rd, busy
  );
endinterface

// File: rtl/iic_slave_regs.sv
// I2C target with 16-bit register pointer and 8-bit data, driving a simple register-file port.
// state     | meaning
// IDLE      | bus ignored until START
// DEV       | shifting in device address + R/W
// DEV_ACK   | acknowledging own address
// AHI/ALO   | shifting in pointer high / low byte
// *_ACK     | acknowledging the byte just received
// WDAT      | shifting in write data
// RDAT      | shifting out read data
// RDAT_ACK  | SDA released, sampling master ACK/NACK
module iic_slave_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h2B,
  parameter int         FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  iic_slave_regs_if.slave bus
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_DEV      = 4'd1;
  localparam logic [3:0] S_DEV_ACK  = 4'd2;
  localparam logic [3:0] S_AHI      = 4'd3;
  localparam logic [3:0] S_AHI_ACK  = 4'd4;
  localparam logic [3:0] S_ALO      = 4'd5;
  localparam logic [3:0] S_ALO_ACK  = 4'd6;
  localparam logic [3:0] S_WDAT     = 4'd7;
  localparam logic [3:0] S_WDAT_ACK = 4'd8;
  localparam logic [3:0] S_RDAT     = 4'd9;
  localparam logic [3:0] S_RDAT_ACK = 4'd10;

  localparam int             FW          = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [FW-1:0]  FILT_RELOAD = FW'(FILT_LEN - 1);

  // index 0 = SCL, index 1 = SDA
  logic [1:0]         sync1, sync2, filt, filt_q;
  logic [1:0][FW-1:0] fcnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      filt   <= 2'b11;
      filt_q <= 2'b11;
      fcnt   <= {2{FILT_RELOAD}};
    end else begin
      sync1  <= {bus.sda_in, bus.scl_in};
      sync2  <= sync1;
      filt_q <= filt;
      // down-counter runs only while the synced level disagrees with the accepted one
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          fcnt[i] <= FILT_RELOAD;
        end else if (fcnt[i] == '0) begin
          filt[i] <= sync2[i];
          fcnt[i] <= FILT_RELOAD;
        end else begin
          fcnt[i] <= fcnt[i] - FW'(1);
        end
      end
    end
  end

  logic scl_f, sda_f, scl_p, sda_p;
  logic scl_rise, scl_fall, start_c, stop_c;

  assign scl_f    = filt[0];
  assign sda_f    = filt[1];
  assign scl_p    = filt_q[0];
  assign sda_p    = filt_q[1];
  assign scl_rise = scl_f & ~scl_p;
  assign scl_fall = ~scl_f & scl_p;
  assign start_c  = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_c   = scl_f & scl_p & ~sda_p & sda_f;

  logic [3:0]  state;
  logic [2:0]  bits_left;
  logic [7:0]  shreg;
  logic [7:0]  rx_byte;
  logic [7:0]  addr_hi;
  logic        rw;
  logic        ack_ph;
  logic        mack;
  logic        cap;
  logic [15:0] reg_addr_r;
  logic [7:0]  reg_wdata_r;
  logic        reg_wr_r;
  logic        reg_rd_r;
  logic        sda_oe;
  logic        busy_r;

  assign rx_byte = {shreg[6:0], sda_f};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      bits_left   <= 3'd7;
      shreg       <= 8'h00;
      addr_hi     <= 8'h00;
      rw          <= 1'b0;
      ack_ph      <= 1'b0;
      mack        <= 1'b1;
      cap         <= 1'b0;
      reg_addr_r  <= 16'h0000;
      reg_wdata_r <= 8'h00;
      reg_wr_r    <= 1'b0;
      reg_rd_r    <= 1'b0;
      sda_oe      <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      reg_wr_r <= 1'b0;
      reg_rd_r <= 1'b0;
      cap      <= reg_rd_r;
      if (start_c) begin
        state     <= S_DEV;
        bits_left <= 3'd7;
        ack_ph    <= 1'b0;
        sda_oe    <= 1'b0;
        cap       <= 1'b0;
      end else if (stop_c) begin
        state  <= S_IDLE;
        sda_oe <= 1'b0;
        busy_r <= 1'b0;
        cap    <= 1'b0;
      end else begin
        // register file answers one cycle after the read strobe
        if (cap && state == S_RDAT) begin
          shreg  <= bus.reg_rdata;
          sda_oe <= ~bus.reg_rdata[7];
        end
        case (state)
          S_DEV, S_AHI, S_ALO, S_WDAT: begin
            if (scl_rise) begin
              shreg <= rx_byte;
              if (bits_left != 3'd0) begin
                bits_left <= bits_left - 3'd1;
              end else begin
                ack_ph <= 1'b0;
                case (state)
                  S_DEV: begin
                    if (rx_byte[7:1] == DEV_ADDR) begin
                      state  <= S_DEV_ACK;
                      rw     <= rx_byte[0];
                      busy_r <= 1'b1;
                    end else begin
                      state <= S_IDLE;
                    end
                  end
                  S_AHI: begin
                    addr_hi <= rx_byte;
                    state   <= S_AHI_ACK;
                  end
                  S_ALO: begin
                    reg_addr_r <= {addr_hi, rx_byte};
                    state      <= S_ALO_ACK;
                  end
                  default: begin
                    reg_wdata_r <= rx_byte;
                    reg_wr_r    <= 1'b1;
                    state       <= S_WDAT_ACK;
                  end
                endcase
              end
            end
          end
          S_DEV_ACK, S_AHI_ACK, S_ALO_ACK, S_WDAT_ACK: begin
            // first fall opens the ACK clock, second fall closes it
            if (scl_fall) begin
              if (!ack_ph) begin
                ack_ph <= 1'b1;
                sda_oe <= 1'b1;
              end else begin
                sda_oe    <= 1'b0;
                bits_left <= 3'd7;
                case (state)
                  S_DEV_ACK: begin
                    if (rw) begin
                      state    <= S_RDAT;
                      reg_rd_r <= 1'b1;
                    end else begin
                      state <= S_AHI;
                    end
                  end
                  S_AHI_ACK: state <= S_ALO;
                  S_ALO_ACK: state <= S_WDAT;
                  default: begin
                    reg_addr_r <= reg_addr_r + 16'd1;
                    state      <= S_WDAT;
                  end
                endcase
              end
            end
          end
          S_RDAT: begin
            if (scl_fall) begin
              shreg  <= {shreg[6:0], 1'b0};
              sda_oe <= ~shreg[6];
            end
            if (scl_rise) begin
              if (bits_left != 3'd0) begin
                bits_left <= bits_left - 3'd1;
              end else begin
                state  <= S_RDAT_ACK;
                ack_ph <= 1'b0;
              end
            end
          end
          S_RDAT_ACK: begin
            if (scl_rise && ack_ph) begin
              mack <= sda_f;
            end
            if (scl_fall) begin
              if (!ack_ph) begin
                ack_ph <= 1'b1;
                sda_oe <= 1'b0;
              end else begin
                reg_addr_r <= reg_addr_r + 16'd1;
                if (!mack) begin
                  state     <= S_RDAT;
                  reg_rd_r  <= 1'b1;
                  bits_left <= 3'd7;
                end else begin
                  state  <= S_IDLE;
                  busy_r <= 1'b0;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.sda_out_en = sda_oe;
  assign bus.reg_addr   = reg_addr_r;
  assign bus.reg_wr     = reg_wr_r;
  assign bus.reg_wdata  = reg_wdata_r;
  assign bus.reg_rd     = reg_rd_r;
  assign bus.busy       = busy_r;

endmodule
